pcie_dn_rdreq_gen: RTL

//  Download-path stage downstream of the free-buffer queue (DN_FBUF). Pops one 96-bit host buffer

---
 rtl/pcie_dn_pkg.sv | 33 +++
 rtl/pcie_dn_chunk_calc.sv | 64 ++++++
 rtl/pcie_dn_rdreq_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pcie_dn_pkg.sv
// Shared definitions for the download-path request generator: descriptor layout,
// FSM encoding and FBUF read timing.
package pcie_dn_pkg;

    localparam int DESC_W      = 96;
    localparam int ADDR_LSB    = 0;
    localparam int ADDR_MSB    = 63;
    localparam int LEN_LSB     = 64;
    localparam int LEN_MSB     = 95;
    localparam int ADDR_W      = 64;
    localparam int REM_W       = 32;
    localparam int RDLEN_W     = 13;
    localparam int FBUF_RD_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_CALC  = 3'd4,
        ST_ISSUE = 3'd5
    } state_e;

    // Requests are dword granular, so the two low bits of address and length are dropped.
    function automatic logic [ADDR_W-1:0] align_dw64(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

    function automatic logic [REM_W-1:0] align_dw32(input logic [REM_W-1:0] a);
        return a & ~REM_W'(3);
    endfunction

endpackage

// File: rtl/pcie_dn_chunk_calc.sv
// Registered chunk splitter: given the current address and remaining length, computes the
// next request size (bounded by MRRS and the MRRS-aligned boundary) plus the follow-on state.
module pcie_dn_chunk_calc
    import pcie_dn_pkg::*;
#(
    parameter int MRRS_BYTES = 512
) (
    input  logic               PCIE_CLK,
    input  logic               PCIE_RST,
    input  logic               calc_en_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [REM_W-1:0]   rem_i,
    output logic [ADDR_W-1:0]  chunk_addr_o,
    output logic [RDLEN_W-1:0] chunk_len_o,
    output logic [ADDR_W-1:0]  next_addr_o,
    output logic [REM_W-1:0]   next_rem_o,
    output logic               last_o
);

    localparam int OFF_W = $clog2(MRRS_BYTES);
    localparam logic [RDLEN_W-1:0] MRRS_LEN = RDLEN_W'(MRRS_BYTES);

    logic [RDLEN_W-1:0] off;
    logic [RDLEN_W-1:0] room;
    logic [RDLEN_W-1:0] chunk;
    logic               last;

    logic [ADDR_W-1:0]  chunk_addr_q;
    logic [RDLEN_W-1:0] chunk_len_q;
    logic [ADDR_W-1:0]  next_addr_q;
    logic [REM_W-1:0]   next_rem_q;
    logic               last_q;

    // When the remainder fits before the boundary it is also <= MRRS, so it fits RDLEN_W bits.
    always_comb begin
        off   = {{(RDLEN_W-OFF_W){1'b0}}, addr_i[OFF_W-1:0]};
        room  = MRRS_LEN - off;
        last  = (rem_i <= {{(REM_W-RDLEN_W){1'b0}}, room});
        chunk = last ? rem_i[RDLEN_W-1:0] : room;
    end

    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            chunk_addr_q <= '0;
            chunk_len_q  <= '0;
            next_addr_q  <= '0;
            next_rem_q   <= '0;
            last_q       <= 1'b0;
        end else if (calc_en_i) begin
            chunk_addr_q <= addr_i;
            chunk_len_q  <= chunk;
            next_addr_q  <= addr_i + {{(ADDR_W-RDLEN_W){1'b0}}, chunk};
            next_rem_q   <= rem_i - {{(REM_W-RDLEN_W){1'b0}}, chunk};
            last_q       <= last;
        end
    end

    assign chunk_addr_o = chunk_addr_q;
    assign chunk_len_o  = chunk_len_q;
    assign next_addr_o  = next_addr_q;
    assign next_rem_o   = next_rem_q;
    assign last_o       = last_q;

endmodule

// File: rtl/pcie_dn_rdreq_gen.sv
// Download-path read request generator: pops host buffer descriptors from DN_FBUF and
// splits each into MRRS-bounded PCIe memory-read requests on a valid/ready interface.
module pcie_dn_rdreq_gen
    import pcie_dn_pkg::*;
#(
    parameter int MRRS_BYTES = 512,
    parameter int POP_GUARD  = 4
) (
    input  logic               PCIE_CLK,
    input  logic               PCIE_RST,
    input  logic               DMA_EN,
    input  logic               DN_FBUF_RD_RDY,
    output logic               DN_FBUF_RD_REQ,
    input  logic [DESC_W-1:0]  DN_FBUF_RD_DATA,
    output logic               RDREQ_VLD,
    input  logic               RDREQ_RDY,
    output logic [ADDR_W-1:0]  RDREQ_ADDR,
    output logic [RDLEN_W-1:0] RDREQ_LEN,
    output logic               RDREQ_FIRST,
    output logic               RDREQ_LAST,
    output logic               BUF_DONE,
    output logic               ERR_LEN0,
    output logic               BUSY
);

    localparam int GUARD_W = $clog2(POP_GUARD + 1);

    state_e             state_q, state_d;
    logic [GUARD_W-1:0] guard_q, guard_d;
    logic [1:0]         lat_q, lat_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic               first_q, first_d;
    logic               vld_q, vld_d;
    logic               req_first_q, req_first_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               calc_en;
    logic [ADDR_W-1:0]  desc_addr;
    logic [REM_W-1:0]   desc_len;
    logic [ADDR_W-1:0]  chunk_addr;
    logic [RDLEN_W-1:0] chunk_len;
    logic [ADDR_W-1:0]  next_addr;
    logic [REM_W-1:0]   next_rem;
    logic               chunk_last;

    pcie_dn_chunk_calc #(
        .MRRS_BYTES (MRRS_BYTES)
    ) u_chunk_calc (
        .PCIE_CLK     (PCIE_CLK),
        .PCIE_RST     (PCIE_RST),
        .calc_en_i    (calc_en),
        .addr_i       (addr_q),
        .rem_i        (rem_q),
        .chunk_addr_o (chunk_addr),
        .chunk_len_o  (chunk_len),
        .next_addr_o  (next_addr),
        .next_rem_o   (next_rem),
        .last_o       (chunk_last)
    );

    always_comb begin
        desc_addr   = align_dw64(DN_FBUF_RD_DATA[ADDR_MSB:ADDR_LSB]);
        desc_len    = align_dw32(DN_FBUF_RD_DATA[LEN_MSB:LEN_LSB]);
        state_d     = state_q;
        guard_d     = (guard_q != '0) ? guard_q - GUARD_W'(1) : guard_q;
        lat_d       = lat_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        first_d     = first_q;
        vld_d       = vld_q;
        req_first_d = req_first_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        calc_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DMA_EN && DN_FBUF_RD_RDY && guard_q == '0) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                // RD_RDY lags the FIFO, so it is masked until the pop has propagated.
                guard_d = GUARD_W'(POP_GUARD - 1);
                lat_d   = 2'(FBUF_RD_LAT - 2);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == 2'd0) begin
                    state_d = ST_LOAD;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_LOAD: begin
                addr_d  = desc_addr;
                rem_d   = desc_len;
                first_d = 1'b1;
                if (desc_len == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                calc_en     = 1'b1;
                vld_d       = 1'b1;
                req_first_d = first_q;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (RDREQ_RDY) begin
                    vld_d   = 1'b0;
                    addr_d  = next_addr;
                    rem_d   = next_rem;
                    first_d = 1'b0;
                    if (chunk_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
        if (PCIE_RST) begin
            state_q     <= ST_IDLE;
            guard_q     <= '0;
            lat_q       <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            first_q     <= 1'b0;
            vld_q       <= 1'b0;
            req_first_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            lat_q       <= lat_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            vld_q       <= vld_d;
            req_first_q <= req_first_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign DN_FBUF_RD_REQ = (state_q == ST_POP);
    assign BUSY           = (state_q != ST_IDLE);
    assign RDREQ_VLD      = vld_q;
    assign RDREQ_ADDR     = chunk_addr;
    assign RDREQ_LEN      = chunk_len;
    assign RDREQ_FIRST    = req_first_q;
    assign RDREQ_LAST     = chunk_last;
    assign BUF_DONE       = done_q;
    assign ERR_LEN0       = err_q;

endmodule
